// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: TITLE -> PLAY -> BOSS -> WIN/OVER, with HP/score/cooldown tracking.
// Optional pause support is enabled by defining GAME_PAUSE_EN.
module game_flow_ctrl #(
    parameter int unsigned HP_INIT      = 5,
    parameter int unsigned BOSS_HP_INIT = 20,
    parameter int unsigned BOSS_SCORE   = 10,
    parameter int unsigned HIT_COOLDOWN = 60,
    parameter int unsigned END_HOLD     = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       enter,
    input  logic       player_hit,
    input  logic       enemy_kill,
    input  logic       boss_hit,
    output logic       play_en,
    output logic       end_en,
    output logic       boss_en,
    output logic       win,
    output logic       obj_rst,
    output logic       invuln,
    output logic [4:0] my_hp,
    output logic [4:0] boss_hp,
    output logic [9:0] score
);

    localparam int unsigned HP_W    = 5;
    localparam int unsigned SCORE_W = 10;
    localparam int unsigned CD_W    = $clog2(HIT_COOLDOWN + 1);
    localparam int unsigned HOLD_W  = $clog2(END_HOLD + 1);

    typedef enum logic [2:0] {
        TITLE = 3'd0,
        PLAY  = 3'd1,
        BOSS  = 3'd2,
        WIN   = 3'd3,
        OVER  = 3'd4
`ifdef GAME_PAUSE_EN
        ,
        PAUSE = 3'd5
`endif
    } state_t;

    state_t              state, state_n;
    logic                prev_vsync, prev_enter;
    logic [CD_W-1:0]     cooldown, cd_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [HP_W-1:0]     my_hp_n, boss_hp_n;
    logic [SCORE_W-1:0]  score_n;
    logic                play_en_n, end_en_n, boss_en_n, win_n, obj_rst_n, invuln_n;
    logic                run;
    logic                frame_tick, enter_rise;
`ifdef GAME_PAUSE_EN
    state_t              ret_state, ret_n;
`endif

    assign frame_tick = prev_vsync & ~vsync;
    assign enter_rise = enter & ~prev_enter;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= TITLE;
            prev_vsync <= 1'b1;
            prev_enter <= 1'b0;
            cooldown   <= '0;
            hold_cnt   <= '0;
            my_hp      <= '0;
            boss_hp    <= '0;
            score      <= '0;
            play_en    <= 1'b0;
            end_en     <= 1'b0;
            boss_en    <= 1'b0;
            win        <= 1'b0;
            obj_rst    <= 1'b0;
            invuln     <= 1'b0;
`ifdef GAME_PAUSE_EN
            ret_state  <= TITLE;
`endif
        end else begin
            state      <= state_n;
            prev_vsync <= vsync;
            prev_enter <= enter;
            cooldown   <= cd_n;
            hold_cnt   <= hold_n;
            my_hp      <= my_hp_n;
            boss_hp    <= boss_hp_n;
            score      <= score_n;
            play_en    <= play_en_n;
            end_en     <= end_en_n;
            boss_en    <= boss_en_n;
            win        <= win_n;
            obj_rst    <= obj_rst_n;
            invuln     <= invuln_n;
`ifdef GAME_PAUSE_EN
            ret_state  <= ret_n;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cd_n      = cooldown;
        hold_n    = hold_cnt;
        my_hp_n   = my_hp;
        boss_hp_n = boss_hp;
        score_n   = score;
        obj_rst_n = 1'b0;
        run       = 1'b0;
`ifdef GAME_PAUSE_EN
        ret_n     = ret_state;
`endif

        case (state)
            TITLE: begin
                if (enter_rise) begin
                    state_n   = PLAY;
                    my_hp_n   = HP_W'(HP_INIT);
                    boss_hp_n = '0;
                    score_n   = '0;
                    cd_n      = '0;
                    obj_rst_n = 1'b1;
                end
            end
            PLAY, BOSS: begin
                run = 1'b1;
`ifdef GAME_PAUSE_EN
                if (enter_rise) begin
                    state_n = PAUSE;
                    ret_n   = state;
                    run     = 1'b0;
                end
`endif
            end
            WIN, OVER: begin
                if (frame_tick && hold_cnt != HOLD_W'(END_HOLD))
                    hold_n = hold_cnt + 1'b1;
                if (enter_rise && hold_cnt == HOLD_W'(END_HOLD))
                    state_n = TITLE;
            end
`ifdef GAME_PAUSE_EN
            PAUSE: begin
                if (enter_rise)
                    state_n = ret_state;
            end
`endif
            default: state_n = TITLE;
        endcase

        // All gameplay counters update in parallel; OVER overrides WIN/BOSS
        if (run) begin
            if (player_hit && cooldown == '0) begin
                if (my_hp != '0)
                    my_hp_n = my_hp - 1'b1;
                cd_n = CD_W'(HIT_COOLDOWN);
            end else if (frame_tick && cooldown != '0) begin
                cd_n = cooldown - 1'b1;
            end
            if (enemy_kill && score != '1)
                score_n = score + 1'b1;
            if (state == PLAY && score_n >= SCORE_W'(BOSS_SCORE)) begin
                state_n   = BOSS;
                boss_hp_n = HP_W'(BOSS_HP_INIT);
            end
            if (state == BOSS) begin
                if (boss_hit && boss_hp != '0)
                    boss_hp_n = boss_hp - 1'b1;
                if (boss_hp_n == '0)
                    state_n = WIN;
            end
            if (my_hp_n == '0)
                state_n = OVER;
            if (state_n == WIN || state_n == OVER)
                hold_n = '0;
        end

        play_en_n = (state_n == PLAY) || (state_n == BOSS);
        end_en_n  = (state_n == WIN) || (state_n == OVER);
        win_n     = (state_n == WIN);
        boss_en_n = (state_n == BOSS);
`ifdef GAME_PAUSE_EN
        if (state_n == PAUSE)
            boss_en_n = boss_en;
`endif
        invuln_n  = (cd_n != '0);
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl (default build, pause disabled).
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b1;
    logic       enter = 1'b0;
    logic       player_hit = 1'b0;
    logic       enemy_kill = 1'b0;
    logic       boss_hit = 1'b0;
    logic       play_en, end_en, boss_en, win, obj_rst, invuln;
    logic [4:0] my_hp, boss_hp;
    logic [9:0] score;

    int vectors = 0;
    int errors  = 0;
    int pulses;

    game_flow_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .enter      (enter),
        .player_hit (player_hit),
        .enemy_kill (enemy_kill),
        .boss_hit   (boss_hit),
        .play_en    (play_en),
        .end_en     (end_en),
        .boss_en    (boss_en),
        .win        (win),
        .obj_rst    (obj_rst),
        .invuln     (invuln),
        .my_hp      (my_hp),
        .boss_hp    (boss_hp),
        .score      (score)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b0;
            step();
            vsync = 1'b1;
            step();
        end
    endtask

    task automatic press();
        enter = 1'b1;
        step();
        enter = 1'b0;
        step();
    endtask

    task automatic hit_player();
        player_hit = 1'b1;
        step();
        player_hit = 1'b0;
    endtask

    task automatic kills(input int n);
        for (int i = 0; i < n; i++) begin
            enemy_kill = 1'b1;
            step();
            enemy_kill = 1'b0;
        end
    endtask

    task automatic boss_hits(input int n);
        for (int i = 0; i < n; i++) begin
            boss_hit = 1'b1;
            step();
            boss_hit = 1'b0;
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_play_en", play_en, 0);
        check("rst_end_en",  end_en,  0);
        check("rst_obj_rst", obj_rst, 0);
        check("rst_my_hp",   my_hp,   0);
        check("rst_score",   score,   0);
        rst = 1'b1;
        step();
        step();

        // Start game with enter held for 10 cycles
        enter = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obj_rst) pulses++;
        end
        enter = 1'b0;
        check("start_obj_rst_pulses", pulses, 1);
        check("start_play_en", play_en, 1);
        check("start_my_hp",   my_hp,   5);
        check("start_score",   score,   0);
        check("start_invuln",  invuln,  0);

        // Hit cooldown behaviour
        hit_player();
        check("hit1_my_hp",  my_hp,  4);
        check("hit1_invuln", invuln, 1);
        frames(5);
        hit_player();
        check("hit_cd_ignored_my_hp", my_hp, 4);
        check("hit_cd_invuln", invuln, 1);
        frames(54);
        check("cd_last_frame_invuln", invuln, 1);
        frames(1);
        check("cd_expired_invuln", invuln, 0);
        hit_player();
        check("hit2_my_hp", my_hp, 3);

        // Score to boss threshold
        kills(9);
        check("kill9_score",   score,   9);
        check("kill9_boss_en", boss_en, 0);
        kills(1);
        check("kill10_score",   score,   10);
        check("kill10_boss_en", boss_en, 1);
        check("kill10_boss_hp", boss_hp, 20);
        check("kill10_play_en", play_en, 1);

        // Defeat the boss
        boss_hits(19);
        check("boss19_boss_hp", boss_hp, 1);
        check("boss19_win",     win,     0);
        boss_hits(1);
        check("boss20_win",     win,     1);
        check("boss20_end_en",  end_en,  1);
        check("boss20_play_en", play_en, 0);
        check("boss20_boss_en", boss_en, 0);
        kills(1);
        check("win_kill_ignored_score", score, 10);

        // End-screen hold before enter is accepted
        frames(50);
        press();
        check("win_f50_enter_ignored", end_en, 1);
        frames(69);
        press();
        check("win_f119_enter_ignored", end_en, 1);
        frames(1);
        press();
        check("win_f120_end_en", end_en, 0);
        check("win_f120_win",    win,    0);
        check("win_f120_play_en", play_en, 0);

        // Second game: simultaneous death and boss kill goes to OVER
        enter = 1'b1;
        step();
        check("restart_obj_rst", obj_rst, 1);
        check("restart_my_hp",   my_hp,   5);
        check("restart_score",   score,   0);
        enter = 1'b0;
        step();
        check("restart_obj_rst_off", obj_rst, 0);
        for (int i = 0; i < 4; i++) begin
            hit_player();
            frames(60);
        end
        check("g2_my_hp", my_hp, 1);
        check("g2_invuln", invuln, 0);
        kills(10);
        check("g2_boss_en", boss_en, 1);
        boss_hits(19);
        check("g2_boss_hp", boss_hp, 1);
        player_hit = 1'b1;
        boss_hit   = 1'b1;
        step();
        player_hit = 1'b0;
        boss_hit   = 1'b0;
        check("over_end_en",  end_en,  1);
        check("over_win",     win,     0);
        check("over_my_hp",   my_hp,   0);
        check("over_boss_hp", boss_hp, 0);
        check("over_play_en", play_en, 0);

        // Asynchronous reset in the middle of BOSS
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        press();
        kills(10);
        check("g3_boss_en", boss_en, 1);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_boss_en", boss_en, 0);
        check("async_rst_play_en", play_en, 0);
        check("async_rst_my_hp",   my_hp,   0);
        check("async_rst_score",   score,   0);
        check("async_rst_boss_hp", boss_hp, 0);
        step();
        rst = 1'b1;
        step();
        enter = 1'b1;
        step();
        enter = 1'b0;
        check("post_rst_title_start", play_en, 1);
        check("post_rst_my_hp",       my_hp,   5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
